// File: rtl/e1000_intr_pkg.sv
// -----------------------------------------------------------------------------
// e1000_intr_pkg
//   Constants and types shared by the e1000 interrupt moderation stages and the
//   interrupt controller: timer unit length, ICR cause bit positions, the
//   moderation FSM state encoding and the RDTR flush bit position.
// -----------------------------------------------------------------------------
package e1000_intr_pkg;

    // Hardware delay timers count in units of 1.024 us.
    localparam int TIMER_UNIT_NS = 1024;

    // ICR cause bit positions.
    localparam int ICR_TXDW   = 0;
    localparam int ICR_LSC    = 2;
    localparam int ICR_RXDMT0 = 4;
    localparam int ICR_RXT0   = 7;

    // RDTR bit 31: flush partial descriptor block (write-only action bit).
    localparam int RDTR_FPD_BIT = 31;

    // Width of the delay fields held in RDTR/RADV/TIDV/TADV.
    localparam int DELAY_W = 16;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } intr_state_e;

    // Number of clk cycles in one timer unit for a given clock period.
    function automatic int tick_cycles(input int clk_period_ns);
        return TIMER_UNIT_NS / clk_period_ns;
    endfunction

endpackage : e1000_intr_pkg

// File: rtl/intr_tick_gen.sv
// -----------------------------------------------------------------------------
// intr_tick_gen
//   Timer-unit prescaler for the interrupt delay stages. Counts
//   0..TICK_CYCLES-1 while enabled and asserts tick_o for one cycle on the
//   wrap. A clear forces the count back to 0 and suppresses the tick, so a
//   fresh delay always starts on a full timer unit.
//
// Ports
//   clk_i   in   1  clock
//   rst_i   in   1  reset, asynchronous, active-high
//   en_i    in   1  count enable
//   clr_i   in   1  synchronous clear (wins over en_i)
//   tick_o  out  1  one-cycle timer-unit tick
// -----------------------------------------------------------------------------
module intr_tick_gen #(
    parameter int TICK_CYCLES = 128
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int            CW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] presc_q, presc_d;

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        presc_d = presc_q;
        if (clr_i) begin
            presc_d = '0;
        end else if (en_i) begin
            presc_d = (presc_q == LAST) ? '0 : presc_q + CW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    assign tick_o = en_i && !clr_i && (presc_q == LAST);

endmodule : intr_tick_gen

// File: rtl/rx_intr_delay.sv
// -----------------------------------------------------------------------------
// rx_intr_delay
//   Receive interrupt moderation in front of intr_ctrl. Per-packet write-back
//   completions arm the RDTR packet delay timer (restarted by every packet) and
//   the RADV absolute delay timer (armed once by the first packet). Whichever
//   expires first, or an RDTR write with the FPD bit set, raises a one-cycle
//   RXT0_req cause pulse (ICR bit 7) one cycle after the event.
//
// Build option
//   RX_ABS_TIMER_EN  defined: RADV register and absolute timer present.
//                    undefined: RADV/RADV_set ignored, RADV_fb_o reads 0.
//
// Ports
//   clk_i       in   1   clock
//   rst_i       in   1   reset, asynchronous, active-high
//   RDTR        in   32  RDTR write data; [15:0] delay, [31] FPD flush
//   RDTR_set    in   1   RDTR write strobe
//   RADV        in   32  RADV write data; [15:0] absolute delay
//   RADV_set    in   1   RADV write strobe
//   RDTR_fb_o   out  32  RDTR readback {16'b0, rdtr_val}; FPD reads 0
//   RADV_fb_o   out  32  RADV readback {16'b0, radv_val}
//   pkt_done_i  in   1   one pulse per packet written back to host
//   RXT0_req    out  1   one-cycle receive timer interrupt cause
//   pending_o   out  1   packets written back but not yet signalled
// -----------------------------------------------------------------------------
module rx_intr_delay
    import e1000_intr_pkg::*;
#(
    parameter int CLK_PERIOD_NS = 8,
    parameter int TICK_CYCLES   = tick_cycles(CLK_PERIOD_NS)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] RDTR,
    input  logic        RDTR_set,
    input  logic [31:0] RADV,
    input  logic        RADV_set,
    output logic [31:0] RDTR_fb_o,
    output logic [31:0] RADV_fb_o,
    input  logic        pkt_done_i,
    output logic        RXT0_req,
    output logic        pending_o
);

    intr_state_e        state_q, state_d;
    logic [DELAY_W-1:0] rdtr_val_q, rdtr_val_d;
    logic [DELAY_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic               rxt0_req_q;

    logic tick;
    logic fire;
    logic enter_pend;
    logic fpd;
    logic pkt_expire;
    logic abs_expire;

    // Prescaler only runs while packets are outstanding and is held at 0 in
    // IDLE, so it is already cleared on the IDLE->PENDING edge.
    intr_tick_gen #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick_gen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (state_q == ST_PENDING),
        .clr_i  (state_q == ST_IDLE),
        .tick_o (tick)
    );

    assign rdtr_val_d = RDTR_set ? RDTR[DELAY_W-1:0] : rdtr_val_q;
    assign fpd        = RDTR_set && RDTR[RDTR_FPD_BIT];
    assign pkt_expire = tick && (pkt_cnt_q == DELAY_W'(1));

`ifdef RX_ABS_TIMER_EN
    logic [DELAY_W-1:0] radv_val_q, radv_val_d;
    logic [DELAY_W-1:0] abs_cnt_q, abs_cnt_d;
    logic               unused_bits;

    assign unused_bits = ^{RDTR[30:DELAY_W], RADV[31:DELAY_W]};
    assign radv_val_d  = RADV_set ? RADV[DELAY_W-1:0] : radv_val_q;
    assign abs_expire  = tick && (abs_cnt_q == DELAY_W'(1));
    assign RADV_fb_o   = {16'b0, radv_val_q};

    // Absolute timer: loaded only on entry to PENDING, never by later packets.
    // A zero load leaves it idle for the whole pending period.
    always_comb begin
        abs_cnt_d = abs_cnt_q;
        if (fire) begin
            abs_cnt_d = '0;
        end else if (enter_pend) begin
            abs_cnt_d = radv_val_q;
        end else if (state_q == ST_PENDING && tick && abs_cnt_q != '0) begin
            abs_cnt_d = abs_cnt_q - DELAY_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            radv_val_q <= '0;
            abs_cnt_q  <= '0;
        end else begin
            radv_val_q <= radv_val_d;
            abs_cnt_q  <= abs_cnt_d;
        end
    end
`else
    logic unused_bits;

    assign unused_bits = ^{RDTR[30:DELAY_W], RADV, RADV_set};
    assign abs_expire  = 1'b0;
    assign RADV_fb_o   = '0;
`endif

    always_comb begin
        state_d    = state_q;
        pkt_cnt_d  = pkt_cnt_q;
        fire       = 1'b0;
        enter_pend = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pkt_done_i) begin
                    if (rdtr_val_q == '0) begin
                        // A packet landing in the pulse cycle is covered by
                        // the interrupt already being raised.
                        fire = !rxt0_req_q;
                    end else begin
                        enter_pend = 1'b1;
                        state_d    = ST_PENDING;
                        pkt_cnt_d  = rdtr_val_q;
                    end
                end
            end
            ST_PENDING: begin
                // A packet restarts the packet timer even on a tick.
                if (pkt_done_i) begin
                    pkt_cnt_d = rdtr_val_q;
                end else if (tick && pkt_cnt_q != '0) begin
                    pkt_cnt_d = pkt_cnt_q - DELAY_W'(1);
                end
                if (pkt_expire || abs_expire || fpd ||
                    (pkt_done_i && rdtr_val_q == '0)) begin
                    fire = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (fire) begin
            state_d   = ST_IDLE;
            pkt_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            rdtr_val_q <= '0;
            pkt_cnt_q  <= '0;
            rxt0_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdtr_val_q <= rdtr_val_d;
            pkt_cnt_q  <= pkt_cnt_d;
            rxt0_req_q <= fire;
        end
    end

    assign RXT0_req  = rxt0_req_q;
    assign pending_o = (state_q == ST_PENDING);
    assign RDTR_fb_o = {16'b0, rdtr_val_q};

endmodule : rx_intr_delay

// File: tb/tb_rx_intr_delay.sv
// -----------------------------------------------------------------------------
// tb_rx_intr_delay
//   Self-checking bench for rx_intr_delay (default parameters: 8 ns clock,
//   128 cycles per timer unit). A reference model predicts every cycle from
//   absolute deadline cycles (packet deadline = N-th tick after the latest
//   packet, absolute deadline = entry + RADV ticks). Follows RX_ABS_TIMER_EN.
// -----------------------------------------------------------------------------
module tb_rx_intr_delay;

    localparam longint TICK = 128;
`ifdef RX_ABS_TIMER_EN
    localparam bit ABS_EN = 1'b1;
`else
    localparam bit ABS_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] RDTR = '0;
    logic        RDTR_set = 1'b0;
    logic [31:0] RADV = '0;
    logic        RADV_set = 1'b0;
    logic [31:0] RDTR_fb_o;
    logic [31:0] RADV_fb_o;
    logic        pkt_done_i = 1'b0;
    logic        RXT0_req;
    logic        pending_o;

    rx_intr_delay dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .RDTR       (RDTR),
        .RDTR_set   (RDTR_set),
        .RADV       (RADV),
        .RADV_set   (RADV_set),
        .RDTR_fb_o  (RDTR_fb_o),
        .RADV_fb_o  (RADV_fb_o),
        .pkt_done_i (pkt_done_i),
        .RXT0_req   (RXT0_req),
        .pending_o  (pending_o)
    );

    always #4 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit     m_pend;
    bit     m_pulse;
    longint m_rdtr, m_radv;
    longint m_edge, m_entry, m_pkt_dl, m_abs_dl;

    task automatic model_reset();
        m_pend = 0; m_pulse = 0; m_rdtr = 0; m_radv = 0;
        m_edge = 0; m_entry = 0; m_pkt_dl = -1; m_abs_dl = -1;
    endtask

    task automatic model_edge(input logic pkt, input logic rset, input logic [31:0] rdat,
                              input logic aset, input logic [31:0] adat);
        bit fire;
        fire = 0;
        m_edge++;
        if (!m_pend) begin
            if (pkt) begin
                if (m_rdtr == 0) begin
                    fire = !m_pulse;
                end else begin
                    m_pend   = 1;
                    m_entry  = m_edge;
                    m_pkt_dl = m_edge + TICK * m_rdtr;
                    m_abs_dl = (ABS_EN && m_radv != 0) ? m_edge + TICK * m_radv : -1;
                end
            end
        end else begin
            if (m_edge == m_pkt_dl || m_edge == m_abs_dl) fire = 1;
            if (rset && rdat[31]) fire = 1;
            if (pkt) begin
                if (m_rdtr == 0) fire = 1;
                else m_pkt_dl = m_entry + TICK * ((m_edge - m_entry) / TICK + 1)
                                + TICK * (m_rdtr - 1);
            end
        end
        if (fire) m_pend = 0;
        m_pulse = fire;
        if (rset) m_rdtr = longint'(rdat[15:0]);
        if (aset && ABS_EN) m_radv = longint'(adat[15:0]);
    endtask

    // One clock: drive, predict, advance, compare against the model.
    task automatic step(input logic pkt, input logic rset, input logic [31:0] rdat,
                        input logic aset, input logic [31:0] adat);
        pkt_done_i = pkt; RDTR_set = rset; RDTR = rdat; RADV_set = aset; RADV = adat;
        model_edge(pkt, rset, rdat, aset, adat);
        @(posedge clk_i);
        #1;
        pkt_done_i = 0; RDTR_set = 0; RADV_set = 0;
        check("model_req",  RXT0_req,  m_pulse);
        check("model_pend", pending_o, m_pend);
        check("model_rdtr_fb", RDTR_fb_o, m_rdtr);
        check("model_radv_fb", RADV_fb_o, m_radv);
    endtask

    task automatic idle();
        step(0, 0, 32'd0, 0, 32'd0);
    endtask

    task automatic do_reset();
        rst_i = 1;
        model_reset();
        #2;
        check("rst_req",  RXT0_req,  0);
        check("rst_pend", pending_o, 0);
        check("rst_rdtr_fb", RDTR_fb_o, 0);
        check("rst_radv_fb", RADV_fb_o, 0);
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 0;
    endtask

    typedef struct {
        logic        pkt;
        logic        rset;
        logic [31:0] rdat;
        logic        exp_req;
        logic        exp_pend;
        logic [31:0] exp_rdtr_fb;
    } vec_t;

    vec_t vecs[13];

    int     found, lat, pend_at, pend_before, pulses, prev_pend;
    logic   r_pkt, r_rset, r_aset;
    logic [31:0] r_rdat, r_adat;

    initial begin
        vecs[0]  = '{0, 1, 32'h0000_0000, 0, 0, 32'h0};
        vecs[1]  = '{1, 0, 32'h0000_0000, 1, 0, 32'h0};
        vecs[2]  = '{0, 0, 32'h0000_0000, 0, 0, 32'h0};
        vecs[3]  = '{1, 0, 32'h0000_0000, 1, 0, 32'h0};
        vecs[4]  = '{1, 0, 32'h0000_0000, 0, 0, 32'h0};
        vecs[5]  = '{0, 1, 32'h0000_0003, 0, 0, 32'h3};
        vecs[6]  = '{1, 0, 32'h0000_0000, 0, 1, 32'h3};
        vecs[7]  = '{0, 1, 32'h8000_0005, 1, 0, 32'h5};
        vecs[8]  = '{0, 1, 32'h8000_0005, 0, 0, 32'h5};
        vecs[9]  = '{1, 0, 32'h0000_0000, 0, 1, 32'h5};
        vecs[10] = '{0, 1, 32'h0000_0000, 0, 1, 32'h0};
        vecs[11] = '{1, 0, 32'h0000_0000, 1, 0, 32'h0};
        vecs[12] = '{0, 0, 32'h0000_0000, 0, 0, 32'h0};

        do_reset();

        // Short deterministic vectors: zero delay, pulse-cycle packet, FPD.
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].pkt, vecs[i].rset, vecs[i].rdat, 0, 32'd0);
            check($sformatf("vec%0d_req", i),  RXT0_req,  vecs[i].exp_req);
            check($sformatf("vec%0d_pend", i), pending_o, vecs[i].exp_pend);
            check($sformatf("vec%0d_fb", i),   RDTR_fb_o, vecs[i].exp_rdtr_fb);
        end

        // RDTR=4, RADV=0, single packet: pulse 512 cycles later.
        do_reset();
        step(0, 1, 32'd4, 1, 32'd0);
        step(1, 0, 32'd0, 0, 32'd0);
        found = 0; lat = 0; pend_at = 1; pend_before = 0;
        for (int j = 1; j <= 600; j++) begin
            prev_pend = pending_o;
            idle();
            if (RXT0_req && found == 0) begin
                found = 1; lat = j; pend_at = pending_o; pend_before = prev_pend;
            end
        end
        check("rdtr4_pulse_seen", found, 1);
        check("rdtr4_latency", lat, 512);
        check("rdtr4_pend_before", pend_before, 1);
        check("rdtr4_pend_at_pulse", pend_at, 0);

        // Packet in the expiry cycle: one pulse, IDLE, nothing afterwards.
        step(0, 1, 32'd2, 0, 32'd0);
        step(1, 0, 32'd0, 0, 32'd0);
        for (int j = 1; j < 256; j++) idle();
        step(1, 0, 32'd0, 0, 32'd0);
        check("expiry_pkt_req", RXT0_req, 1);
        check("expiry_pkt_pend", pending_o, 0);
        pulses = 0;
        for (int j = 0; j < 400; j++) begin
            idle();
            if (RXT0_req) pulses++;
        end
        check("expiry_no_followup", pulses, 0);

        // FPD flush while pending.
        step(0, 1, 32'd100, 0, 32'd0);
        step(1, 0, 32'd0, 0, 32'd0);
        for (int j = 0; j < 50; j++) idle();
        check("fpd_pend_before", pending_o, 1);
        step(0, 1, 32'h8000_0064, 0, 32'd0);
        check("fpd_req", RXT0_req, 1);
        check("fpd_fb", RDTR_fb_o, 32'h64);
        idle();
        check("fpd_single_pulse", RXT0_req, 0);

`ifdef RX_ABS_TIMER_EN
        // RDTR=4, RADV=10, packets every 256 cycles: absolute timer fires.
        do_reset();
        step(0, 1, 32'd4, 1, 32'd10);
        check("abs_radv_fb", RADV_fb_o, 32'd10);
        found = 0; lat = 0; pulses = 0;
        for (int j = 0; j < 3000; j++) begin
            step((j % 256) == 0, 0, 32'd0, 0, 32'd0);
            if (RXT0_req) begin
                pulses++;
                if (found == 0) begin found = 1; lat = j; end
            end
        end
        check("abs_first_pulse", lat, 1280);
        check("abs_pulse_count", pulses, 2);
`else
        // Absolute timer absent: RADV ignored, only the packet timer fires.
        do_reset();
        step(0, 0, 32'd0, 1, 32'd2);
        step(0, 1, 32'd50, 0, 32'd0);
        check("noabs_radv_fb", RADV_fb_o, 0);
        step(1, 0, 32'd0, 0, 32'd0);
        found = 0; lat = 0;
        for (int j = 1; j <= 6500; j++) begin
            idle();
            if (RXT0_req && found == 0) begin found = 1; lat = j; end
        end
        check("noabs_pulse_seen", found, 1);
        check("noabs_latency", lat, 6400);
`endif

        // Reset while pending: everything dropped, no late pulse.
        step(0, 1, 32'd7, 1, 32'd3);
        step(1, 0, 32'd0, 0, 32'd0);
        for (int j = 0; j < 100; j++) idle();
        check("midrst_pend_before", pending_o, 1);
        do_reset();
        pulses = 0;
        for (int j = 0; j < 2000; j++) begin
            idle();
            if (RXT0_req) pulses++;
        end
        check("midrst_no_pulse", pulses, 0);
        check("midrst_pend_after", pending_o, 0);

        // Random traffic and register writes against the model.
        for (int n = 0; n < 15000; n++) begin
            r_pkt  = ($urandom_range(0, 119) == 0);
            r_rset = ($urandom_range(0, 299) == 0);
            r_rdat = {($urandom_range(0, 3) == 0), 15'd0, 16'($urandom_range(0, 5))};
            r_aset = ($urandom_range(0, 399) == 0);
            r_adat = 32'($urandom_range(0, 8));
            step(r_pkt, r_rset, r_rdat, r_aset, r_adat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_rx_intr_delay
